// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the Gray-pointer dual-clock FIFO
package fifo_pkg;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_sync_bus.sv
// fifo_sync_bus: STAGES-deep flop synchroniser for a WIDTH-bit bus, cleared by async active-low reset
module fifo_sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/async_fifo_gray.sv
// async_fifo_gray: dual-clock FIFO with Gray-coded pointer crossing, occupancy flags and per-domain reset release
module async_fifo_gray
  import fifo_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int AF_LEVEL    = 2**AW - 2,
  parameter int AE_LEVEL    = 2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          rst,
  input  logic          wr_clk,
  input  logic          rd_clk,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          almost_full,
  output logic          overflow,
  output logic [AW:0]   wr_data_count,
  output logic          wr_rst_busy,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          empty,
  output logic          almost_empty,
  output logic          underflow,
  output logic [AW:0]   rd_data_count,
  output logic          rd_rst_busy
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);
  logic [DW-1:0] mem [DEPTH];
  logic wr_rst_sync, rd_rst_sync;
  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d, rgray_w, rbin_w, wr_cnt_q, wr_cnt_d;
  logic full_q, full_d, af_q, af_d, ovf_q, ovf_d, wbusy_q, wbusy_d, wr_ok;
  logic [AW:0] rbin_q, rbin_d, rgray_q, rgray_d, wgray_r, wbin_r, rd_cnt_q, rd_cnt_d;
  logic empty_q, empty_d, ae_q, ae_d, unf_q, unf_d, rbusy_q, rbusy_d, valid_q, valid_d, rd_ok;
  logic [DW-1:0] dout_q, dout_d;
  fifo_sync_bus #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_wr_rst (.clk(wr_clk), .rst(rst), .d(1'b1), .q(wr_rst_sync));
  fifo_sync_bus #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rd_rst (.clk(rd_clk), .rst(rst), .d(1'b1), .q(rd_rst_sync));
  fifo_sync_bus #(.WIDTH(AW+1), .STAGES(SYNC_STAGES)) u_rg2w (.clk(wr_clk), .rst(rst), .d(rgray_q), .q(rgray_w));
  fifo_sync_bus #(.WIDTH(AW+1), .STAGES(SYNC_STAGES)) u_wg2r (.clk(rd_clk), .rst(rst), .d(wgray_q), .q(wgray_r));
  // Flags hold their reset values until the busy flag drops, then recompute from the pointers.
  always_comb begin
    wbusy_d  = !wr_rst_sync;
    wr_ok    = wr_en && !full_q && !wbusy_q;
    wbin_d   = wbin_q + (AW+1)'(wr_ok);
    wgray_d  = (AW+1)'(bin2gray(32'(wbin_d)));
    rbin_w   = (AW+1)'(gray2bin(32'(rgray_w)));
    wr_cnt_d = wbin_d - rbin_w;
    full_d   = wbusy_d || (wgray_d == {~rgray_w[AW:AW-1], rgray_w[AW-2:0]});
    af_d     = wbusy_d || (wr_cnt_d >= AF_L);
    ovf_d    = wr_en && (full_q || wbusy_q);
  end
  always_ff @(posedge wr_clk or negedge rst)
    if (!rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wr_cnt_q <= '0;
      full_q   <= 1'b1;
      af_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wbusy_q  <= 1'b1;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wr_cnt_q <= wr_cnt_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      wbusy_q  <= wbusy_d;
    end
  always_ff @(posedge wr_clk)
    if (wr_ok) mem[wbin_q[AW-1:0]] <= din;
  always_comb begin
    rbusy_d  = !rd_rst_sync;
    rd_ok    = rd_en && !empty_q && !rbusy_q;
    rbin_d   = rbin_q + (AW+1)'(rd_ok);
    rgray_d  = (AW+1)'(bin2gray(32'(rbin_d)));
    wbin_r   = (AW+1)'(gray2bin(32'(wgray_r)));
    rd_cnt_d = wbin_r - rbin_d;
    empty_d  = rbusy_d || (rgray_d == wgray_r);
    ae_d     = rbusy_d || (rd_cnt_d <= AE_L);
    unf_d    = rd_en && (empty_q || rbusy_q);
    valid_d  = rd_ok;
    dout_d   = rd_ok ? mem[rbin_q[AW-1:0]] : dout_q;
  end
  always_ff @(posedge rd_clk or negedge rst)
    if (!rst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rd_cnt_q <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      unf_q    <= 1'b0;
      rbusy_q  <= 1'b1;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rd_cnt_q <= rd_cnt_d;
      empty_q  <= empty_d;
      ae_q     <= ae_d;
      unf_q    <= unf_d;
      rbusy_q  <= rbusy_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  assign full          = full_q;
  assign almost_full   = af_q;
  assign overflow      = ovf_q;
  assign wr_data_count = wr_cnt_q;
  assign wr_rst_busy   = wbusy_q;
  assign dout          = dout_q;
  assign valid         = valid_q;
  assign empty         = empty_q;
  assign almost_empty  = ae_q;
  assign underflow     = unf_q;
  assign rd_data_count = rd_cnt_q;
  assign rd_rst_busy   = rbusy_q;
endmodule

// File: tb/tb_async_fifo_gray.sv
// tb_async_fifo_gray: scenario bench for the dual-clock FIFO against a queue-based reference
module tb_async_fifo_gray;
  localparam int DW = 8, AW = 4, SS = 2;
  logic rst, wr_clk, rd_clk, wr_en, rd_en;
  logic [DW-1:0] din, dout;
  logic full, almost_full, overflow, wr_rst_busy, valid, empty, almost_empty, underflow, rd_rst_busy;
  logic [AW:0] wr_data_count, rd_data_count;
  int n_vec = 0, n_err = 0;
  int wr_half = 50, rd_half = 135;
  logic [7:0] sb [$];

  async_fifo_gray #(.DW(DW), .AW(AW), .AF_LEVEL(12), .AE_LEVEL(3), .SYNC_STAGES(SS)) dut (
    .rst(rst), .wr_clk(wr_clk), .rd_clk(rd_clk),
    .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full), .overflow(overflow),
    .wr_data_count(wr_data_count), .wr_rst_busy(wr_rst_busy),
    .rd_en(rd_en), .dout(dout), .valid(valid), .empty(empty), .almost_empty(almost_empty),
    .underflow(underflow), .rd_data_count(rd_data_count), .rd_rst_busy(rd_rst_busy)
  );

  initial begin wr_clk = 0; forever #(wr_half) wr_clk = ~wr_clk; end
  initial begin rd_clk = 0; forever #(rd_half) rd_clk = ~rd_clk; end
  initial begin
    #40000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int wn = 0, rn = 0;
    rst = 0; wr_en = 0; rd_en = 0; din = '0;
    #20;
    n_vec++;
    if ({full, almost_full, wr_rst_busy, empty, almost_empty, rd_rst_busy, overflow, underflow, valid} !== 9'b111111000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected %b", {full, almost_full, wr_rst_busy, empty, almost_empty, rd_rst_busy, overflow, underflow, valid}, 9'b111111000);
    end
    n_vec++;
    if ({dout, wr_data_count, rd_data_count} !== 18'h0) begin
      n_err++; $display("FAIL reset_data: dout/wcnt/rcnt got %0h/%0d/%0d expected 0/0/0", dout, wr_data_count, rd_data_count);
    end
    repeat (3) @(posedge rd_clk);
    @(posedge wr_clk); #32; rst = 1;
    fork
      while (wr_rst_busy && wn < 20) begin @(posedge wr_clk); #10; wn++; end
      while (rd_rst_busy && rn < 20) begin @(posedge rd_clk); #10; rn++; end
    join
    n_vec++;
    if (wn != SS + 1 || rn != SS + 1) begin
      n_err++; $display("FAIL busy_release: wr/rd cycles got %0d/%0d expected %0d/%0d", wn, rn, SS + 1, SS + 1);
    end
    n_vec++;
    if ({full, almost_full, empty, almost_empty, wr_data_count, rd_data_count} !== {4'b0011, 10'h0}) begin
      n_err++;
      $display("FAIL post_reset: full/af/empty/ae got %b wcnt %0d rcnt %0d expected 0011 0 0", {full, almost_full, empty, almost_empty}, wr_data_count, rd_data_count);
    end
  endtask

  task automatic test_single_write();
    int n = 0;
    @(posedge wr_clk); #10; wr_en = 1; din = 8'h3C;
    @(posedge wr_clk);
    fork begin #10; wr_en = 0; end join_none
    while (empty && n < 20) begin @(posedge rd_clk); #10; n++; end
    n_vec++;
    if (n < SS + 1 || n > SS + 2) begin
      n_err++; $display("FAIL empty_latency: got %0d rd edges expected %0d..%0d", n, SS + 1, SS + 2);
    end
    n_vec++;
    if (rd_data_count !== 5'd1) begin
      n_err++; $display("FAIL single_rcnt: got %0d expected 1", rd_data_count);
    end
    rd_en = 1; @(posedge rd_clk); #10; rd_en = 0;
    n_vec++;
    if ({valid, empty, dout, rd_data_count} !== {2'b11, 8'h3C, 5'd0}) begin
      n_err++; $display("FAIL single_read: valid/empty got %b%b dout %0h rcnt %0d expected 11 3c 0", valid, empty, dout, rd_data_count);
    end
    repeat (8) @(posedge wr_clk); #10;
    n_vec++;
    if ({full, wr_data_count} !== 6'h0) begin
      n_err++; $display("FAIL single_wside: full %b wcnt %0d expected 0 0", full, wr_data_count);
    end
  endtask

  task automatic test_fill();
    @(posedge wr_clk); #10;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; din = 8'(i);
      @(posedge wr_clk); #10;
      n_vec++;
      if ({full, almost_full, wr_data_count} !== {i == 15, i >= 11, 5'(i + 1)}) begin
        n_err++;
        $display("FAIL fill_%0d: full/af got %b%b wcnt %0d expected %b%b %0d", i, full, almost_full, wr_data_count, i == 15, i >= 11, i + 1);
      end
    end
    din = 8'hEE;
    @(posedge wr_clk); #10; wr_en = 0;
    n_vec++;
    if ({overflow, full, wr_data_count} !== {2'b11, 5'd16}) begin
      n_err++; $display("FAIL overflow_pulse: ovf/full got %b%b wcnt %0d expected 11 16", overflow, full, wr_data_count);
    end
    @(posedge wr_clk); #10;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_drain();
    repeat (6) @(posedge rd_clk); #10;
    n_vec++;
    if ({empty, almost_empty, rd_data_count} !== {2'b00, 5'd16}) begin
      n_err++; $display("FAIL drain_start: empty/ae got %b%b rcnt %0d expected 00 16", empty, almost_empty, rd_data_count);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      @(posedge rd_clk); #10;
      n_vec++;
      if ({valid, dout, empty, almost_empty, rd_data_count} !== {1'b1, 8'(i), i == 15, (15 - i) <= 3, 5'(15 - i)}) begin
        n_err++;
        $display("FAIL drain_%0d: valid %b dout %0h empty/ae %b%b rcnt %0d expected 1 %0h %b%b %0d", i, valid, dout, empty, almost_empty, rd_data_count, i, i == 15, (15 - i) <= 3, 15 - i);
      end
    end
    @(posedge rd_clk); #10; rd_en = 0;
    n_vec++;
    if ({underflow, valid, dout} !== {2'b10, 8'h0F}) begin
      n_err++; $display("FAIL underflow_pulse: unf/valid got %b%b dout %0h expected 10 0f", underflow, valid, dout);
    end
    @(posedge rd_clk); #10;
    n_vec++;
    if ({underflow, dout} !== {1'b0, 8'h0F}) begin
      n_err++; $display("FAIL underflow_clear: unf %b dout %0h expected 0 0f", underflow, dout);
    end
    repeat (6) @(posedge wr_clk); #10;
    n_vec++;
    if ({full, almost_full, wr_data_count} !== 7'h0) begin
      n_err++; $display("FAIL drain_wside: full/af got %b%b wcnt %0d expected 00 0", full, almost_full, wr_data_count);
    end
  endtask

  task automatic test_stream(input int wh, input int rh);
    int wi = 0, rj = 0, wg = 0, rg = 0;
    bit wtook, rtook;
    logic [7:0] exp;
    wr_half = wh; rd_half = rh;
    repeat (4) @(posedge wr_clk);
    repeat (4) @(posedge rd_clk);
    sb.delete();
    fork
      begin
        @(posedge wr_clk); #10;
        while (wi < 1000 && wg < 20000) begin
          wr_en = !full && ($urandom_range(0, 3) != 0);
          din = 8'(wi);
          wtook = wr_en;
          @(posedge wr_clk); #10; wg++;
          if (wtook) begin sb.push_back(din); wi++; end
          n_vec++;
          if (overflow !== 1'b0) begin n_err++; $display("FAIL stream_overflow: got %b expected 0 at write %0d", overflow, wi); end
        end
        wr_en = 0;
      end
      begin
        @(posedge rd_clk); #10;
        while (rj < 1000 && rg < 20000) begin
          rd_en = !empty && ($urandom_range(0, 3) != 0);
          rtook = rd_en;
          @(posedge rd_clk); #10; rg++;
          n_vec++;
          if (rtook) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
            if ({valid, dout} !== {1'b1, exp}) begin
              n_err++; $display("FAIL stream_data_%0d: valid %b dout %0h expected 1 %0h", rj, valid, dout, exp);
            end
            rj++;
          end else if ({valid, underflow} !== 2'b00) begin
            n_err++; $display("FAIL stream_idle: valid/unf got %b%b expected 00", valid, underflow);
          end
        end
        rd_en = 0;
      end
    join
    n_vec++;
    if (wi != 1000 || rj != 1000) begin
      n_err++; $display("FAIL stream_count: writes/reads got %0d/%0d expected 1000/1000", wi, rj);
    end
    repeat (8) @(posedge rd_clk);
    repeat (8) @(posedge wr_clk); #10;
    n_vec++;
    if ({empty, rd_data_count, full, wr_data_count} !== {1'b1, 5'd0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL stream_settle: empty %b rcnt %0d full %b wcnt %0d expected 1 0 0 0", empty, rd_data_count, full, wr_data_count);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    wr_half = 50; rd_half = 135;
    repeat (4) @(posedge wr_clk); #10;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; din = 8'(8'h50 + i);
      @(posedge wr_clk); #10;
    end
    n_vec++;
    if (wr_data_count !== 5'd9) begin
      n_err++; $display("FAIL mid_fill: wcnt got %0d expected 9", wr_data_count);
    end
    test_reset();
    @(posedge wr_clk); #10; wr_en = 1; din = 8'hA5;
    @(posedge wr_clk); #10; wr_en = 0;
    while (empty && n < 20) begin @(posedge rd_clk); #10; n++; end
    n_vec++;
    if (rd_data_count !== 5'd1) begin
      n_err++; $display("FAIL mid_rcnt: got %0d expected 1 after %0d rd edges", rd_data_count, n);
    end
    rd_en = 1; @(posedge rd_clk); #10; rd_en = 0;
    n_vec++;
    if ({valid, dout, empty} !== {1'b1, 8'hA5, 1'b1}) begin
      n_err++; $display("FAIL mid_readback: valid %b dout %0h empty %b expected 1 a5 1", valid, dout, empty);
    end
  endtask

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; din = '0;
    #10;
    test_reset();
    test_single_write();
    test_fill();
    test_drain();
    test_stream(50, 155);
    test_stream(155, 50);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
